// File: rtl/lru_age_tracker_if.sv
// lru_age_tracker_if
//   Bundles the event and query traffic between the cache controller and the
//   LRU age tracker.
//
//   Handshake semantics (single comment for the whole bus):
//     touch_valid, inval_valid and query_valid are plain valid strobes with no
//     ready. The tracker accepts one of each in every cycle and never stalls.
//     cand_valid is a one-cycle pulse that follows an accepted query by exactly
//     one clock. candidates/cand_full are meaningful only while cand_valid is 1.
//     Between pulses they hold the last result, or zero after reset.
//
//   Signals
//     touch_valid/touch_fill/touch_set/touch_way : hit (fill=0) or fill (fill=1) event
//     inval_valid/inval_set/inval_way            : invalidate one line
//     query_valid/query_set                      : victim query request
//     cand_valid/candidates/cand_full            : registered query result
//
//   Modports
//     master : cache controller side (drives events and queries)
//     slave  : tracker side (drives query results)
interface lru_age_tracker_if #(
  parameter int LOG_WAYS = 2,
  parameter int LOG_SETS = 6
);
  localparam int WAYS = 1 << LOG_WAYS;

  logic                touch_valid;
  logic                touch_fill;
  logic [LOG_SETS-1:0] touch_set;
  logic [LOG_WAYS-1:0] touch_way;

  logic                inval_valid;
  logic [LOG_SETS-1:0] inval_set;
  logic [LOG_WAYS-1:0] inval_way;

  logic                query_valid;
  logic [LOG_SETS-1:0] query_set;

  logic                cand_valid;
  logic [WAYS-1:0]     candidates;
  logic                cand_full;

  modport master (
    output touch_valid, touch_fill, touch_set, touch_way,
    output inval_valid, inval_set, inval_way,
    output query_valid, query_set,
    input  cand_valid, candidates, cand_full
  );

  modport slave (
    input  touch_valid, touch_fill, touch_set, touch_way,
    input  inval_valid, inval_set, inval_way,
    input  query_valid, query_set,
    output cand_valid, candidates, cand_full
  );
endinterface

// File: rtl/lru_age_tracker.sv
// lru_age_tracker
//   True-LRU bookkeeping for a set-associative cache. Each set keeps one age
//   per way (0 = most recently used, WAYS-1 = least recently used) and one
//   valid bit per way. A query returns a registered victim-candidate vector for
//   the downstream priority encoder:
//     - any invalid way in the set : every invalid way is flagged, cand_full=0
//     - all ways valid             : only the LRU way is flagged,  cand_full=1
//
//   Ports
//     clk      : clock, all state changes on the rising edge
//     reset_n  : synchronous reset, active low
//     bus      : lru_age_tracker_if.slave (events in, query results out)
//
//   The ages in each set always form a permutation of 0..WAYS-1. A touch only
//   increments ways younger than the touched way, so no age can pass WAYS-1.
module lru_age_tracker #(
  parameter int LOG_WAYS = 2,
  parameter int LOG_SETS = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  lru_age_tracker_if.slave   bus
);

  localparam int WAYS = 1 << LOG_WAYS;
  localparam int SETS = 1 << LOG_SETS;
  localparam logic [LOG_WAYS-1:0] AGE_LRU = LOG_WAYS'(WAYS - 1);
  localparam logic [LOG_WAYS-1:0] AGE_ONE = LOG_WAYS'(1);

  typedef logic [WAYS-1:0][LOG_WAYS-1:0] age_row_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  age_row_t        age_q [SETS];
  logic [WAYS-1:0] vld_q [SETS];

  logic            cand_valid_q;
  logic [WAYS-1:0] candidates_q;
  logic            cand_full_q;

  // Reset value of one set's age row: way w starts with age w.
  function automatic age_row_t reset_row();
    age_row_t r;
    for (int w = 0; w < WAYS; w++) begin
      r[w] = LOG_WAYS'(w);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Touch: compute the new age row for the touched set
  // ---------------------------------------------------------------------------
  age_row_t            touch_row;
  age_row_t            touch_row_nxt;
  logic [LOG_WAYS-1:0] touch_old;

  always_comb begin
    touch_row     = age_q[bus.touch_set];
    touch_old     = touch_row[bus.touch_way];
    touch_row_nxt = touch_row;
    for (int w = 0; w < WAYS; w++) begin
      if (LOG_WAYS'(w) == bus.touch_way) begin
        touch_row_nxt[w] = '0;
      end else if (touch_row[w] < touch_old) begin
        // Only ages below touch_old move up, so the largest result is
        // touch_old itself and the increment cannot wrap.
        touch_row_nxt[w] = touch_row[w] + AGE_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Query: victim candidates from pre-edge state (no bypass of same-cycle
  // touch/invalidate)
  // ---------------------------------------------------------------------------
  age_row_t        q_age;
  logic [WAYS-1:0] q_vld;
  logic [WAYS-1:0] q_lru_hot;
  logic            q_all_valid;
  logic [WAYS-1:0] q_cand;

  always_comb begin
    q_age       = age_q[bus.query_set];
    q_vld       = vld_q[bus.query_set];
    q_all_valid = &q_vld;
    q_lru_hot   = '0;
    for (int w = 0; w < WAYS; w++) begin
      q_lru_hot[w] = (q_age[w] == AGE_LRU);
    end
    q_cand = q_all_valid ? q_lru_hot : ~q_vld;
  end

  // ---------------------------------------------------------------------------
  // Sequential update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        age_q[s] <= reset_row();
        vld_q[s] <= '0;
      end
      cand_valid_q <= 1'b0;
      candidates_q <= '0;
      cand_full_q  <= 1'b0;
    end else begin
      if (bus.touch_valid) begin
        age_q[bus.touch_set] <= touch_row_nxt;
        if (bus.touch_fill) begin
          vld_q[bus.touch_set][bus.touch_way] <= 1'b1;
        end
      end
      // Placed after the fill so that an invalidate of the same line in the
      // same cycle leaves the line invalid.
      if (bus.inval_valid) begin
        vld_q[bus.inval_set][bus.inval_way] <= 1'b0;
      end

      cand_valid_q <= bus.query_valid;
      if (bus.query_valid) begin
        candidates_q <= q_cand;
        cand_full_q  <= q_all_valid;
      end
    end
  end

  assign bus.cand_valid = cand_valid_q;
  assign bus.candidates = candidates_q;
  assign bus.cand_full  = cand_full_q;

endmodule

// File: tb/tb_lru_age_tracker.sv
// tb_lru_age_tracker
//   Directed and random stimulus for lru_age_tracker. A reference model of
//   ages and valid bits produces expected query results, which are queued when
//   a query is driven and popped when cand_valid is expected.
module tb_lru_age_tracker;

  localparam int LOG_WAYS = 2;
  localparam int LOG_SETS = 6;
  localparam int WAYS     = 1 << LOG_WAYS;
  localparam int SETS     = 1 << LOG_SETS;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lru_age_tracker_if #(.LOG_WAYS(LOG_WAYS), .LOG_SETS(LOG_SETS)) bus ();

  lru_age_tracker #(.LOG_WAYS(LOG_WAYS), .LOG_SETS(LOG_SETS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  int              m_age [SETS][WAYS];
  bit              m_vld [SETS][WAYS];
  logic [WAYS-1:0] exp_q [$];
  logic            exp_full_q [$];

  int checks = 0;
  int fails  = 0;

  // Directed steps may pin the expected query result to a hand-derived value.
  bit              ovr_en   = 1'b0;
  logic [WAYS-1:0] ovr_cand = '0;
  logic            ovr_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_age[s][w] = w;
        m_vld[s][w] = 1'b0;
      end
    end
  endtask

  task automatic model_query(input int s, output logic [WAYS-1:0] cand, output logic full);
    full = 1'b1;
    for (int w = 0; w < WAYS; w++) if (!m_vld[s][w]) full = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      cand[w] = full ? (m_age[s][w] == WAYS - 1) : !m_vld[s][w];
    end
  endtask

  task automatic model_touch(input int s, input int w, input bit fill);
    int old;
    old = m_age[s][w];
    for (int i = 0; i < WAYS; i++) begin
      if (i == w) m_age[s][i] = 0;
      else if (m_age[s][i] < old) m_age[s][i] = m_age[s][i] + 1;
    end
    if (fill) m_vld[s][w] = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    bus.touch_valid = 1'b0;
    bus.touch_fill  = 1'b0;
    bus.touch_set   = '0;
    bus.touch_way   = '0;
    bus.inval_valid = 1'b0;
    bus.inval_set   = '0;
    bus.inval_way   = '0;
    bus.query_valid = 1'b0;
    bus.query_set   = '0;
    ovr_en          = 1'b0;
  endtask

  // One clock with whatever is currently driven, then check the outputs.
  task automatic cycle(input string tag);
    logic [WAYS-1:0] c;
    logic            f;
    bit              q_exp;
    q_exp = 1'b0;
    if (!reset_n) begin
      model_reset();
      exp_q.delete();
      exp_full_q.delete();
    end else begin
      if (bus.query_valid) begin
        model_query(int'(bus.query_set), c, f);
        if (ovr_en) begin
          c = ovr_cand;
          f = ovr_full;
        end
        exp_q.push_back(c);
        exp_full_q.push_back(f);
        q_exp = 1'b1;
      end
      if (bus.touch_valid) model_touch(int'(bus.touch_set), int'(bus.touch_way), bus.touch_fill);
      if (bus.inval_valid) m_vld[bus.inval_set][bus.inval_way] = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, ".cand_valid"}, 32'(bus.cand_valid), 32'(q_exp));
    if (!reset_n) begin
      chk({tag, ".rst_candidates"}, 32'(bus.candidates), 32'd0);
      chk({tag, ".rst_cand_full"},  32'(bus.cand_full),  32'd0);
    end else if (q_exp && exp_q.size() > 0) begin
      c = exp_q.pop_front();
      f = exp_full_q.pop_front();
      chk({tag, ".candidates"}, 32'(bus.candidates), 32'(c));
      chk({tag, ".cand_full"},  32'(bus.cand_full),  32'(f));
    end
    idle_inputs();
  endtask

  task automatic touch(input int s, input int w, input bit fill);
    bus.touch_valid = 1'b1;
    bus.touch_fill  = fill;
    bus.touch_set   = LOG_SETS'(s);
    bus.touch_way   = LOG_WAYS'(w);
  endtask

  task automatic inval(input int s, input int w);
    bus.inval_valid = 1'b1;
    bus.inval_set   = LOG_SETS'(s);
    bus.inval_way   = LOG_WAYS'(w);
  endtask

  task automatic query(input int s);
    bus.query_valid = 1'b1;
    bus.query_set   = LOG_SETS'(s);
  endtask

  task automatic query_exp(input int s, input logic [WAYS-1:0] c, input logic f);
    query(s);
    ovr_en   = 1'b1;
    ovr_cand = c;
    ovr_full = f;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence followed by random traffic
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    reset_n = 1'b0;
    cycle("reset0");
    cycle("reset1");
    reset_n = 1'b1;

    // 1: fresh set, all ways invalid
    query_exp(5, 4'b1111, 1'b0); cycle("t1_query");

    // 2: fill ways in order, way0 becomes LRU
    for (int w = 0; w < WAYS; w++) begin
      touch(5, w, 1'b1); cycle("t2_fill");
    end
    query_exp(5, 4'b0001, 1'b1); cycle("t2_query");

    // 3: hits reorder ages to {1,3,0,2}
    touch(5, 0, 1'b0); cycle("t3_hit0");
    touch(5, 2, 1'b0); cycle("t3_hit2");
    query_exp(5, 4'b0010, 1'b1); cycle("t3_query");

    // 4: invalidate not visible to a same-cycle query
    inval(5, 3); query_exp(5, 4'b0010, 1'b1); cycle("t4_same");
    query_exp(5, 4'b1000, 1'b0); cycle("t4_next");

    // 5: fill + invalidate same line, invalidate wins
    touch(7, 0, 1'b1); cycle("t5_fill0");
    touch(7, 2, 1'b1); cycle("t5_fill2");
    touch(7, 3, 1'b1); cycle("t5_fill3");
    touch(7, 1, 1'b1); inval(7, 1); cycle("t5_both");
    query_exp(7, 4'b0010, 1'b0); cycle("t5_query");
    // way1 is now MRU: filling it makes way0 (filled first) the LRU
    touch(7, 1, 1'b1); cycle("t5_refill");
    query_exp(7, 4'b0001, 1'b1); cycle("t5_query2");

    // Hold behaviour: no query -> cand_valid low, outputs unchanged
    cycle("hold");
    chk("hold.candidates", 32'(bus.candidates), 32'(4'b0001));
    chk("hold.cand_full",  32'(bus.cand_full),  32'd1);

    // 6: query, then reset in the following cycle with an in-flight query
    query(5); cycle("t6_query");
    reset_n = 1'b0; query(5); cycle("t6_reset");
    reset_n = 1'b1;
    query_exp(5, 4'b1111, 1'b0); cycle("t6_set5");
    query_exp(7, 4'b1111, 1'b0); cycle("t6_set7");

    // Random traffic on a few sets to force collisions; every query result
    // (including the single LRU bit when full) is checked against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 60)
        touch($urandom_range(0, 3), $urandom_range(0, WAYS - 1), $urandom_range(0, 99) < 40);
      if ($urandom_range(0, 99) < 15)
        inval($urandom_range(0, 3), $urandom_range(0, WAYS - 1));
      if ($urandom_range(0, 99) < 70)
        query($urandom_range(0, 3));
      cycle("rand");
    end

    // Sweep every set for the permutation/candidate result
    for (int s = 0; s < SETS; s++) begin
      query(s); cycle("sweep");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
